perf_counter_bank: RTL and testbench

- Synthesizable N-channel event/performance counter bank. Replaces ad-hoc statistics counting in benches.
- Counts a free-running cycle count plus NUM_CH per-cycle event strobes. Typical strobes: retired instruction, I/D-cache request, I/D-cache hit.
- Freezes all counts on halt or watchdog timeout.
- Sits beside the cpu top level. Results are read through a one-cycle-latency indexed read port, usable by both the bench and a future debug/MMIO path.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_counter_cell.sv | 60 ++++++
 rtl/perf_counter_bank.sv | 136 +++++++++++++
 tb/tb_perf_counter_bank.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared types and constants for the performance counter bank.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Default event channel assignment used by the cpu top level.
    localparam int CH_INST  = 0;
    localparam int CH_ICREQ = 1;
    localparam int CH_ICHIT = 2;
    localparam int CH_DCREQ = 3;
    localparam int CH_DCHIT = 4;
    localparam int CH_MEMRD = 5;
    localparam int CH_MEMWR = 6;

    // Read-select width: indices 0..numCh, where numCh is the cycle counter.
    function automatic int selWidth(input int numCh);
        return $clog2(numCh + 1);
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one CNT_W counter with saturate/wrap and a sticky
// overflow flag. With PERF_SNAPSHOT_EN defined it also keeps a shadow copy
// that captures the post-update value when cap is high.
module perf_counter_cell #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             frz,
`ifdef PERF_SNAPSHOT_EN
    input  logic             cap,
    output logic [CNT_W-1:0] shadow,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic             atMax;
    logic             bump;
    logic [CNT_W-1:0] cntNext;

    assign atMax = &cnt;
    assign bump  = inc && !frz;

    // Next value: clear wins, then a gated increment with saturate/wrap at all-ones.
    always_comb begin
        cntNext = cnt;
        if (clr) begin
            cntNext = '0;
        end else if (bump) begin
            if (atMax) cntNext = (SATURATE != 0) ? cnt : '0;
            else       cntNext = cnt + CNT_W'(1);
        end
    end

    // Counter register and sticky overflow (set by any increment from all-ones).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cntNext;
            if (clr)                ovf <= 1'b0;
            else if (bump && atMax) ovf <= 1'b1;
        end
    end

`ifdef PERF_SNAPSHOT_EN
    // Shadow copy takes the post-update value so a snap sees this edge's count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      shadow <= '0;
        else if (clr) shadow <= '0;
        else if (cap) shadow <= cntNext;
    end
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters plus a cycle counter, a
// run/halt/timeout FSM and a one-cycle-latency indexed read port.
// Optional macro PERF_SNAPSHOT_EN adds a snap input and shadow registers;
// reads then return the shadow copy instead of the live counters.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int CNT_W     = 32,
    parameter int CYC_LIMIT = 100000,
    parameter int SATURATE  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [NUM_CH-1:0]           ev,
    input  logic                        halt,
`ifdef PERF_SNAPSHOT_EN
    input  logic                        snap,
`endif
    input  logic                        rd_req,
    input  logic [selWidth(NUM_CH)-1:0] rd_sel,
    output logic                        rd_valid,
    output logic [CNT_W-1:0]            rd_data,
    output logic                        running,
    output logic                        done,
    output logic                        timeout,
    output logic [NUM_CH:0]             ovf
);

    localparam int SEL_W = selWidth(NUM_CH);
    localparam int NCNT  = NUM_CH + 1;

    state_t                       state;
    state_t                       stateNext;
    logic                         inRun;
    logic                         frz;
    logic                         wdHit;
    logic [NCNT-1:0]              incVec;
    logic [NCNT-1:0][CNT_W-1:0]   cnt;
    logic [NCNT-1:0][CNT_W-1:0]   rdSrc;
    logic [CNT_W-1:0]             cycPost;
    logic [CNT_W-1:0]             rdMux;

    assign inRun   = (state == RUN);
    assign frz     = !inRun;
    assign incVec  = {1'b1, ev};      // cycle counter sits at index NUM_CH
    assign running = (state == RUN);
    assign done    = (state == HALTED);
    assign timeout = (state == TIMEOUT);

    // Post-increment cycle count for the watchdog, same saturate/wrap rule as the cells.
    always_comb begin
        cycPost = cnt[NUM_CH] + CNT_W'(1);
        if (&cnt[NUM_CH]) cycPost = (SATURATE != 0) ? cnt[NUM_CH] : '0;
    end

    // Compare at 64 bits so a limit beyond the counter range never fires.
    assign wdHit = (CYC_LIMIT != 0) && (64'(cycPost) == 64'(CYC_LIMIT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next state: clear beats everything; halt beats the watchdog; terminal states hold.
    always_comb begin
        stateNext = state;
        if (clear) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) stateNext = RUN;
                RUN: begin
                    if (halt)         stateNext = HALTED;
                    else if (wdHit)   stateNext = TIMEOUT;
                    else if (!enable) stateNext = IDLE;
                end
                default: stateNext = state;
            endcase
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic                       cap;
    logic [NCNT-1:0][CNT_W-1:0] shadow;

    // Auto-capture on the edge that leaves RUN for a terminal state.
    assign cap = snap || (inRun && !clear &&
                          (stateNext == HALTED || stateNext == TIMEOUT));
    assign rdSrc = shadow;
`else
    assign rdSrc = cnt;
`endif

    for (genvar i = 0; i < NCNT; i++) begin : gCell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) uCell (
            .clk    (clk),
            .rst    (rst),
            .inc    (incVec[i]),
            .clr    (clear),
            .frz    (frz),
`ifdef PERF_SNAPSHOT_EN
            .cap    (cap),
            .shadow (shadow[i]),
`endif
            .cnt    (cnt[i]),
            .ovf    (ovf[i])
        );
    end

    // Read mux over the registered values; out-of-range selects read as zero.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) rdMux = rdSrc[i];
        end
    end

    // Read port register: data reflects the pre-update value at the request edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rdMux;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: three bank configurations share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed
// literal expectations. Macro PERF_SNAPSHOT_EN enables the snapshot section.
module tb_perf_counter_bank;

    localparam int ND = 3;
    localparam int NCH = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_TOUT = 3;

    int cfgW   [ND] = '{8, 8, 16};
    int cfgLim [ND] = '{0, 0, 20};
    int cfgSat [ND] = '{1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0, clear = 1'b0, halt = 1'b0, rd_req = 1'b0;
    logic [NCH-1:0] ev = '0;
    logic [2:0] rd_sel = '0;
`ifdef PERF_SNAPSHOT_EN
    logic snap = 1'b0;
`endif

    logic [ND-1:0] rdV, run, dn, to;
    logic [7:0]  rdD0, rdD1;
    logic [15:0] rdD2;
    logic [NCH:0] ovf0, ovf1, ovf2;
    logic [15:0] aRd [ND];
    logic [NCH:0] aOvf [ND];

    assign aRd[0] = {8'h00, rdD0};
    assign aRd[1] = {8'h00, rdD1};
    assign aRd[2] = rdD2;
    assign aOvf[0] = ovf0;
    assign aOvf[1] = ovf1;
    assign aOvf[2] = ovf2;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .CYC_LIMIT(0), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ev(ev), .halt(halt),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rdV[0]), .rd_data(rdD0),
        .running(run[0]), .done(dn[0]), .timeout(to[0]), .ovf(ovf0));

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .CYC_LIMIT(0), .SATURATE(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ev(ev), .halt(halt),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rdV[1]), .rd_data(rdD1),
        .running(run[1]), .done(dn[1]), .timeout(to[1]), .ovf(ovf1));

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(16), .CYC_LIMIT(20), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ev(ev), .halt(halt),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rdV[2]), .rd_data(rdD2),
        .running(run[2]), .done(dn[2]), .timeout(to[2]), .ovf(ovf2));

    // ---------------- behavioural model ----------------
    int              mSt  [ND];
    longint unsigned mCnt [ND][NCH+1];
    longint unsigned mShd [ND][NCH+1];
    bit [NCH:0]      mOvf [ND];
    bit              mRv  [ND];
    longint unsigned mRd  [ND];

    int nChecks = 0;
    int nErr = 0;
    bit chkOn = 1'b0;

    task automatic modelReset();
        for (int d = 0; d < ND; d++) begin
            mSt[d] = M_IDLE; mOvf[d] = '0; mRv[d] = 1'b0; mRd[d] = 0;
            for (int k = 0; k <= NCH; k++) begin mCnt[d][k] = 0; mShd[d][k] = 0; end
        end
    endtask

    task automatic bump(input int d, input int k);
        longint unsigned maxv = (64'd1 << cfgW[d]) - 1;
        if (mCnt[d][k] == maxv) begin
            mOvf[d][k] = 1'b1;
            mCnt[d][k] = (cfgSat[d] != 0) ? maxv : 0;
        end else begin
            mCnt[d][k] = mCnt[d][k] + 1;
        end
    endtask

    task automatic capture(input int d);
        for (int k = 0; k <= NCH; k++) mShd[d][k] = mCnt[d][k];
    endtask

    task automatic modelStep(input int d);
        bit snapNow = 1'b0;
`ifdef PERF_SNAPSHOT_EN
        snapNow = snap;
`endif
        mRv[d] = rd_req;
        if (rd_req) begin
            if (rd_sel > NCH) mRd[d] = 0;
`ifdef PERF_SNAPSHOT_EN
            else mRd[d] = mShd[d][rd_sel];
`else
            else mRd[d] = mCnt[d][rd_sel];
`endif
        end
        if (clear) begin
            mSt[d] = M_IDLE; mOvf[d] = '0;
            for (int k = 0; k <= NCH; k++) begin mCnt[d][k] = 0; mShd[d][k] = 0; end
        end else begin
            if (mSt[d] == M_IDLE) begin
                if (enable) mSt[d] = M_RUN;
            end else if (mSt[d] == M_RUN) begin
                bump(d, NCH);
                for (int k = 0; k < NCH; k++) if (ev[k]) bump(d, k);
                if (halt) begin
                    mSt[d] = M_HALT; capture(d);
                end else if (cfgLim[d] != 0 && mCnt[d][NCH] == longint'(cfgLim[d])) begin
                    mSt[d] = M_TOUT; capture(d);
                end else if (!enable) begin
                    mSt[d] = M_IDLE;
                end
            end
            if (snapNow) capture(d);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else for (int d = 0; d < ND; d++) modelStep(d);
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chkOn) begin
            for (int d = 0; d < ND; d++) begin
                chk("running", d, 64'(run[d]), 64'(mSt[d] == M_RUN));
                chk("done",    d, 64'(dn[d]),  64'(mSt[d] == M_HALT));
                chk("timeout", d, 64'(to[d]),  64'(mSt[d] == M_TOUT));
                chk("ovf",     d, 64'(aOvf[d]), 64'(mOvf[d]));
                chk("rd_valid", d, 64'(rdV[d]), 64'(mRv[d]));
                chk("rd_data", d, 64'(aRd[d]), mRd[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    // One read request; checks DUT and model against hand-computed values.
    task automatic rdLit(input string nm, input logic [2:0] sel,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        logic [15:0] e [ND];
        e[0] = e0; e[1] = e1; e[2] = e2;
        rd_req = 1'b1; rd_sel = sel; cyc(); rd_req = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk({nm, "_valid"}, d, 64'(rdV[d]), 64'd1);
            chk(nm, d, 64'(aRd[d]), 64'(e[d]));
            chk({nm, "_model"}, d, mRd[d], 64'(e[d]));
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chkOn = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("reset_state", d, 64'({run[d], dn[d], to[d], rdV[d]}), 64'd0);
            chk("reset_ovf", d, 64'(aOvf[d]), 64'd0);
        end

        // ev[0] for 10 RUN cycles, halt on the 10th.
        enable = 1'b1; cyc();
        ev = 4'b0001;
        repeat (9) cyc();
        halt = 1'b1; cyc();
        halt = 1'b0; ev = '0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk("halt_done", d, 64'(dn[d]), 64'd1);
        rdLit("halt_ch0", 3'd0, 16'd10, 16'd10, 16'd10);
        rdLit("halt_cyc", 3'd4, 16'd10, 16'd10, 16'd10);
        ev = '1; halt = 1'b1;
        repeat (5) cyc();
        ev = '0; halt = 1'b0;
        rdLit("frozen_ch0", 3'd0, 16'd10, 16'd10, 16'd10);
        rdLit("frozen_cyc", 3'd4, 16'd10, 16'd10, 16'd10);
        rdLit("sel_oob5", 3'd5, 16'd0, 16'd0, 16'd0);
        rdLit("sel_oob7", 3'd7, 16'd0, 16'd0, 16'd0);

        // Watchdog on dut2 after exactly 20 RUN cycles.
        doClear();
        enable = 1'b1; cyc();
        for (int i = 0; i < 19; i++) begin ev = 4'($urandom); cyc(); end
        @(negedge clk);
        chk("wd_early", 2, 64'({to[2], run[2]}), 64'b01);
        cyc();
        ev = '0;
        @(negedge clk);
        chk("wd_fire", 2, 64'({to[2], run[2]}), 64'b10);
        rdLit("wd_cyc", 3'd4, 16'd20, 16'd20, 16'd20);
        enable = 1'b0; cyc();

        // 300 events on channel 1: saturate vs wrap at 8 bits.
        doClear();
        enable = 1'b1; cyc();
        ev = 4'b0010;
        repeat (300) cyc();
        ev = '0; enable = 1'b0; cyc();
        rdLit("ovf_ch1", 3'd1, 16'd255, 16'd44, 16'd20);
        chk("ovf_bit1", 0, 64'(aOvf[0][1]), 64'd1);
        chk("ovf_bit1", 1, 64'(aOvf[1][1]), 64'd1);
        chk("ovf_bit1", 2, 64'(aOvf[2][1]), 64'd0);

        // clear beats halt, events and enable in the same cycle.
        doClear();
        enable = 1'b1; cyc();
        repeat (5) begin ev = 4'($urandom); cyc(); end
        clear = 1'b1; halt = 1'b1; ev = '1; cyc();
        clear = 1'b0; halt = 1'b0; ev = '0; enable = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++)
            chk("clear_state", d, 64'({run[d], dn[d], to[d], aOvf[d]}), 64'd0);
        for (int s = 0; s <= NCH; s++) rdLit("clear_rd", 3'(s), 16'd0, 16'd0, 16'd0);

`ifdef PERF_SNAPSHOT_EN
        // Snapshot after 5 events, 5 more live events, then halt auto-capture.
        doClear();
        enable = 1'b1; cyc();
        ev = 4'b0001;
        repeat (4) cyc();
        snap = 1'b1; cyc(); snap = 1'b0;
        repeat (5) cyc();
        ev = '0;
        rdLit("snap_rd", 3'd0, 16'd5, 16'd5, 16'd5);
        halt = 1'b1; cyc(); halt = 1'b0;
        rdLit("snap_halt", 3'd0, 16'd10, 16'd10, 16'd10);
`endif

        // Randomized traffic.
        doClear();
        for (int i = 0; i < 4000; i++) begin
            clear  = ($urandom_range(399) == 0);
            halt   = ($urandom_range(299) == 0);
            enable = ($urandom_range(7) != 0);
            ev     = 4'($urandom);
            rd_req = 1'($urandom);
            rd_sel = 3'($urandom);
`ifdef PERF_SNAPSHOT_EN
            snap   = ($urandom_range(15) == 0);
`endif
            cyc();
        end
        clear = 1'b0; halt = 1'b0;

        // Async reset mid-RUN, no clock edge needed.
        doClear();
        enable = 1'b1; cyc();
        ev = '1;
        repeat (8) cyc();
        rd_req = 1'b1; rd_sel = 3'd4; cyc(); rd_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("async_rst_state", d, 64'({run[d], dn[d], to[d], rdV[d]}), 64'd0);
            chk("async_rst_rd", d, 64'(aRd[d]), 64'd0);
            chk("async_rst_ovf", d, 64'(aOvf[d]), 64'd0);
        end
        cyc();
        rst = 1'b0; enable = 1'b0; ev = '0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule
